// File: rtl/cla_cbya_adder32_pkg.sv
// Shared widths and result type for the dual-architecture adder.
// Result type is sized for the default width.
package adder_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_GROUP  = 4;
  localparam int NUM_GROUPS = DEF_WIDTH / DEF_GROUP;

  typedef struct packed {
    logic                 cout;
    logic [DEF_WIDTH-1:0] sum;
  } result_t;

endpackage

// File: rtl/cla_cbya_adder32_slices.sv
// GROUP-bit slices: lookahead group (sum, group G/P) and ripple block with bypass mux.
// Both purely combinational; no handshake.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             gg,
  output logic             gp
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP-1:0] c;
  logic             acc;
  logic             prod;
  logic             g_acc;
  logic             p_acc;

  assign g = a & b;
  assign p = a ^ b;

  // Each internal carry is a flat sum-of-products over g/p and cin.
  always_comb begin
    c    = '0;
    acc  = 1'b0;
    prod = 1'b0;
    c[0] = cin;
    for (int i = 0; i < GROUP - 1; i++) begin
      acc  = g[i];
      prod = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc  = acc | (prod & g[j]);
        prod = prod & p[j];
      end
      c[i+1] = acc | (prod & cin);
    end
  end

  always_comb begin
    g_acc = g[GROUP-1];
    p_acc = p[GROUP-1];
    for (int j = GROUP - 2; j >= 0; j--) begin
      g_acc = g_acc | (p_acc & g[j]);
      p_acc = p_acc & p[j];
    end
  end

  assign sum = p ^ c;
  assign gg  = g_acc;
  assign gp  = p_acc;

endmodule

module cbya_block #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP:0]   rc;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    rc    = '0;
    rc[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      rc[i+1] = g[i] | (p[i] & rc[i]);
    end
  end

  assign sum = p ^ rc[GROUP-1:0];
  // Full-propagate block forwards its carry-in without waiting on the ripple.
  assign cout = (&p) ? cin : rc[GROUP];

endmodule

// File: rtl/cla_cbya_adder32.sv
// Adds a+b with a two-level CLA and a carry-bypass adder, registers both plus a disagreement flag.
// One cycle latency, one result per cycle, no backpressure.
module cla_cbya_adder32
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GROUP = DEF_GROUP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] cla_sum,
  output logic             cla_cout,
  output logic [WIDTH-1:0] cbya_sum,
  output logic             cbya_cout,
  output logic             mismatch
);

  localparam int NG = WIDTH / GROUP;

  logic [NG-1:0]    gg;
  logic [NG-1:0]    gp;
  logic [NG:0]      gc;
  logic [NG:0]      bc;
  logic [WIDTH-1:0] cla_s;
  logic [WIDTH-1:0] cbya_s;
  logic             c_acc;
  logic             p_acc;
  logic             diff;

  // Second-level lookahead: every group carry-in straight from group G/P, carry-in 0.
  always_comb begin
    gc    = '0;
    c_acc = 1'b0;
    p_acc = 1'b0;
    for (int k = 1; k <= NG; k++) begin
      c_acc = gg[k-1];
      p_acc = gp[k-1];
      for (int j = k - 2; j >= 0; j--) begin
        c_acc = c_acc | (p_acc & gg[j]);
        p_acc = p_acc & gp[j];
      end
      gc[k] = c_acc;
    end
  end

  assign bc[0] = 1'b0;

  for (genvar gi = 0; gi < NG; gi++) begin : g_slice
    cla_group #(.GROUP(GROUP)) u_cla (
      .a   (a[gi*GROUP +: GROUP]),
      .b   (b[gi*GROUP +: GROUP]),
      .cin (gc[gi]),
      .sum (cla_s[gi*GROUP +: GROUP]),
      .gg  (gg[gi]),
      .gp  (gp[gi])
    );

    cbya_block #(.GROUP(GROUP)) u_cbya (
      .a    (a[gi*GROUP +: GROUP]),
      .b    (b[gi*GROUP +: GROUP]),
      .cin  (bc[gi]),
      .sum  (cbya_s[gi*GROUP +: GROUP]),
      .cout (bc[gi+1])
    );
  end

  assign diff = {gc[NG], cla_s} != {bc[NG], cbya_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      cla_sum   <= '0;
      cla_cout  <= 1'b0;
      cbya_sum  <= '0;
      cbya_cout <= 1'b0;
      mismatch  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        cla_sum   <= cla_s;
        cla_cout  <= gc[NG];
        cbya_sum  <= cbya_s;
        cbya_cout <= bc[NG];
        mismatch  <= diff;
      end
    end
  end

endmodule

// File: tb/tb_cla_cbya_adder32.sv
// Scoreboarded bench for cla_cbya_adder32: directed corner vectors, reset, hold and a random burst.
module tb_cla_cbya_adder32;
  import adder_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic [31:0] cla_sum;
  logic        cla_cout;
  logic [31:0] cbya_sum;
  logic        cbya_cout;
  logic        mismatch;

  int tests;
  int fails;
  result_t q[$];
  result_t last;

  cla_cbya_adder32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .cla_sum   (cla_sum),
    .cla_cout  (cla_cout),
    .cbya_sum  (cbya_sum),
    .cbya_cout (cbya_cout),
    .mismatch  (mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Hand-computed directed vectors: {a, b, cout, sum}.
  logic [31:0] da [10] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'h00000002, 32'h0000000C,
                           32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'h00000000};
  logic [31:0] db [10] = '{32'h00000001, 32'h80000000, 32'hFFFFFFF4, 32'hFFFFFFFB, 32'h00000019,
                           32'h00000008, 32'h0000000A, 32'h00000001, 32'hF0F0F0F1, 32'h00000000};
  logic [31:0] ds [10] = '{32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFEF, 32'hFFFFFFFD, 32'h00000025,
                           32'h0000000F, 32'h0000000A, 32'h00000000, 32'h00000000, 32'h00000000};
  logic        dc [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  task automatic issue(input logic v, input logic [31:0] ia, input logic [31:0] ib, input result_t e);
    @(posedge clk);
    #1;
    in_valid = v;
    a        = ia;
    b        = ib;
    if (v) q.push_back(e);
  endtask

  // Monitor: pops on every valid output; otherwise checks the result registers held.
  initial begin
    last = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last = '0;
      end else if (out_valid) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: out_valid=1 with no pending result");
        end else begin
          last = q.pop_front();
          chk("cla", {31'd0, cla_cout, cla_sum}, {31'd0, last.cout, last.sum});
          chk("cbya", {31'd0, cbya_cout, cbya_sum}, {31'd0, last.cout, last.sum});
          chk("mismatch", {63'd0, mismatch}, 64'd0);
        end
      end else begin
        chk("hold_cla", {31'd0, cla_cout, cla_sum}, {31'd0, last.cout, last.sum});
        chk("hold_cbya", {31'd0, cbya_cout, cbya_sum}, {31'd0, last.cout, last.sum});
      end
    end
  end

  initial begin
    result_t e;
    logic [31:0] ra;
    logic [31:0] rb;
    int wait_cnt;
    tests    = 0;
    fails    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_outputs", {cla_cout, cla_sum, cbya_cout, cbya_sum, mismatch}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      e.cout = dc[i];
      e.sum  = ds[i];
      issue(1'b1, da[i], db[i], e);
    end
    issue(1'b0, 32'h0, 32'h0, '0);
    issue(1'b0, 32'h0, 32'h0, '0);
    chk("idle_out_valid", {63'd0, out_valid}, 64'd0);

    // Reset lands while one result is visible and another is about to be captured.
    issue(1'b1, 32'h12345678, 32'h11111111, '{cout: 1'b0, sum: 32'h23456789});
    issue(1'b1, 32'h80000000, 32'h80000000, '{cout: 1'b1, sum: 32'h00000000});
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_rst_outputs", {cla_cout, cla_sum, cbya_cout, cbya_sum, mismatch}, 64'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
    end

    for (int i = 0; i < 3000; i++) begin
      ra     = $urandom;
      rb     = $urandom;
      if (i % 7 == 0) rb = ~ra;
      {e.cout, e.sum} = {1'b0, ra} + {1'b0, rb};
      issue($urandom_range(0, 3) != 0, ra, rb, e);
    end
    issue(1'b0, 32'h0, 32'h0, '0);

    wait_cnt = 0;
    while (q.size() != 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    @(negedge clk);
    chk("drain", {32'd0, q.size()}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
